// File: rtl/dcache_wb_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-back data cache.
package dcache_wb_pkg;

    localparam int ADDR_W         = 30;
    localparam int MEM_ADDR_W     = 28;
    localparam int WORD_W         = 32;
    localparam int BLOCK_WORDS    = 4;
    localparam int LINE_W         = WORD_W * BLOCK_WORDS;
    localparam int OFFSET_W       = $clog2(BLOCK_WORDS);
    localparam int DEF_NUM_BLOCKS = 8;
    localparam int INDEX_W        = $clog2(DEF_NUM_BLOCKS);
    localparam int TAG_W          = MEM_ADDR_W - INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_ALLOCATE
    } state_t;

endpackage

// File: rtl/dcache_wb_array.sv
// Register-based line storage: valid/dirty/tag/data with one read port and
// one write port that either fills a whole line or updates one word.
module dcache_wb_array
    import dcache_wb_pkg::*;
#(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int IDX_W      = INDEX_W,
    parameter int TG_W       = TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    rd_index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TG_W-1:0]     rd_tag,
    output logic [LINE_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic                wr_line,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic [TG_W-1:0]     wr_tag,
    input  logic [OFFSET_W-1:0] wr_word,
    input  logic [LINE_W-1:0]   wr_line_data,
    input  logic [WORD_W-1:0]   wr_word_data
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TG_W-1:0]       tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            if (wr_line) begin
                valid_q[wr_index] <= 1'b1;
                dirty_q[wr_index] <= 1'b0;
            end else begin
                dirty_q[wr_index] <= 1'b1;
            end
        end
    end

    // Tag and data carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_line) begin
                tag_q[wr_index]  <= wr_tag;
                data_q[wr_index] <= wr_line_data;
            end else begin
                for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
                    if (wr_word == w[OFFSET_W-1:0])
                        data_q[wr_index][w*WORD_W +: WORD_W] <= wr_word_data;
                end
            end
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache in front of a slow
// line-wide memory; FSM and hit logic live here, storage in dcache_wb_array.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int NUM_BLOCKS      = DEF_NUM_BLOCKS,
    parameter int WORDS_PER_BLOCK = BLOCK_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  proc_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]     mem_wdata,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  mem_ready
);

    localparam int LINE_IDX_W = $clog2(NUM_BLOCKS);
    localparam int LINE_TAG_W = MEM_ADDR_W - LINE_IDX_W;

    state_t state_q, state_d;

    logic [OFFSET_W-1:0]   off;
    logic [LINE_IDX_W-1:0] idx;
    logic [LINE_TAG_W-1:0] tag;
    logic                  rd_valid, rd_dirty;
    logic [LINE_TAG_W-1:0] rd_tag;
    logic [LINE_W-1:0]     rd_data;
    logic [WORD_W-1:0]     hit_word;
    logic                  hit, req;
    logic                  wr_en, wr_line;

    assign off = proc_addr[OFFSET_W-1:0];
    assign idx = proc_addr[OFFSET_W +: LINE_IDX_W];
    assign tag = proc_addr[ADDR_W-1 -: LINE_TAG_W];
    assign hit = rd_valid && (rd_tag == tag);
    assign req = proc_read || proc_write;

    always_comb begin
        hit_word = '0;
        for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
            if (off == w[OFFSET_W-1:0])
                hit_word = rd_data[w*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_en      = 1'b0;
        wr_line    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read and write is served as a write.
                        if (proc_write) wr_en = 1'b1;
                        else            proc_rdata = hit_word;
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {rd_tag, idx};
                mem_wdata  = rd_data;
                if (mem_ready) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1:OFFSET_W];
                if (mem_ready) begin
                    wr_en   = 1'b1;
                    wr_line = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dcache_wb_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (LINE_IDX_W),
        .TG_W       (LINE_TAG_W)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_index     (idx),
        .rd_valid     (rd_valid),
        .rd_dirty     (rd_dirty),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_line      (wr_line),
        .wr_index     (idx),
        .wr_tag       (tag),
        .wr_word      (off),
        .wr_line_data (mem_rdata),
        .wr_word_data (proc_wdata)
    );

endmodule

// File: tb/tb_dcache_wb.sv
// Randomized self-checking bench for dcache_wb against an array-based cache
// model and a sparse line memory; the bench also plays the slow memory.
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    bit           m_valid [8];
    bit           m_dirty [8];
    logic [24:0]  m_tag   [8];
    logic [127:0] m_data  [8];
    logic [127:0] mem_q   [logic [27:0]];

    always #5 clk = ~clk;

    dcache_wb #(.NUM_BLOCKS(8), .WORDS_PER_BLOCK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mem_get(input logic [27:0] a);
        logic [31:0] w;
        w = {4'h0, a};
        if (mem_q.exists(a)) return mem_q[a];
        return {~w, w ^ 32'hA5A5_0000, w + 32'h0000_1234, w ^ 32'h5A5A_5A5A};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_stall"}, 128'(proc_stall), 128'(0));
        check_val({tag, "_memrw"}, 128'({mem_read, mem_write}), 128'(0));
        check_val({tag, "_rdata"}, 128'(proc_rdata), 128'(0));
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [29:0] addr, input logic [31:0] wd);
        logic [2:0]  idx;
        logic [24:0] tg;
        logic [1:0]  off;
        bit          hit;
        int          lat;
        idx = addr[4:2];
        tg  = addr[29:5];
        off = addr[1:0];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        #1;
        if (!hit) begin
            check_val("miss_stall", 128'(proc_stall), 128'(1));
            check_val("miss_idle_memrw", 128'({mem_read, mem_write}), 128'(0));
            step();
            if (m_valid[idx] && m_dirty[idx]) begin
                lat = $urandom_range(0, 3);
                for (int i = 0; i <= lat; i++) begin
                    check_val("wb_stall", 128'(proc_stall), 128'(1));
                    check_val("wb_memrw", 128'({mem_read, mem_write}), 128'(2'b01));
                    check_val("wb_addr", 128'(mem_addr), 128'({m_tag[idx], idx}));
                    check_val("wb_wdata", mem_wdata, m_data[idx]);
                    if (i == lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    end
                    step();
                    mem_ready = 1'b0;
                end
                mem_q[{m_tag[idx], idx}] = m_data[idx];
            end
            lat = $urandom_range(0, 3);
            for (int i = 0; i <= lat; i++) begin
                check_val("alloc_stall", 128'(proc_stall), 128'(1));
                check_val("alloc_memrw", 128'({mem_read, mem_write}), 128'(2'b10));
                check_val("alloc_addr", 128'(mem_addr), 128'(addr[29:2]));
                if (i == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_get(addr[29:2]);
                end
                step();
                mem_ready = 1'b0;
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = mem_get(addr[29:2]);
        end
        check_val("hit_stall", 128'(proc_stall), 128'(0));
        check_val("hit_memrw", 128'({mem_read, mem_write}), 128'(0));
        check_val("hit_rdata", 128'(proc_rdata), wr ? 128'(0) : 128'(m_data[idx][int'(off)*32 +: 32]));
        step();
        if (wr) begin
            m_data[idx][int'(off)*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        proc_read  = 1'b0;
        proc_write = 1'b0;
        #1;
        check_quiet("after_req");
    endtask

    task automatic idle_ready_pulse();
        check_quiet("pulse_pre");
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        #1;
        check_quiet("pulse_during");
        step();
        mem_ready = 1'b0;
        #1;
        check_quiet("pulse_post");
    endtask

    task automatic reset_mid(input logic [29:0] addr);
        logic [2:0] idx;
        bit         dirty_victim;
        idx = addr[4:2];
        if (m_valid[idx] && (m_tag[idx] == addr[29:5])) return;
        dirty_victim = m_valid[idx] && m_dirty[idx];
        proc_read = 1'b1;
        proc_addr = addr;
        #1;
        step();
        check_val("rst_pre_memrw", 128'({mem_read, mem_write}), dirty_victim ? 128'(2'b01) : 128'(2'b10));
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_memrw", 128'({mem_read, mem_write}), 128'(0));
        proc_read = 1'b0;
        clear_model();
        step();
        rst_n = 1'b1;
        #1;
        check_quiet("rst_mid_after");
    endtask

    initial begin
        clear_model();
        repeat (3) step();
        check_quiet("reset");
        rst_n = 1'b1;
        step();
        check_quiet("post_reset");

        do_access(1'b1, 1'b0, 30'h10, '0);
        do_access(1'b1, 1'b0, 30'h13, '0);
        do_access(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 30'h111, '0);
        do_access(1'b1, 1'b0, 30'h10, '0);
        reset_mid(30'h111);
        do_access(1'b1, 1'b0, 30'h10, '0);
        idle_ready_pulse();
        do_access(1'b1, 1'b0, 30'h12, '0);

        for (int n = 0; n < 400; n++) begin
            logic [29:0] a;
            int          kind;
            a    = {25'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            kind = $urandom_range(0, 39);
            if (kind == 0)       reset_mid(a);
            else if (kind < 3)   idle_ready_pulse();
            else if (kind < 18)  do_access($urandom_range(0, 1) == 1, 1'b1, a, $urandom);
            else                 do_access(1'b1, 1'b0, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 Parameter NUM_BLOCKS, default 8, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS_PER_BLOCK, fixed 4, 32-bit words per line; line = 128 bits, matching the slow_memory word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 proc_read  input  1  processor load request, held while proc_stall=1.
REQ-006 proc_write  input  1  processor store request, held while proc_stall=1.
REQ-007 proc_addr  input  30  word address: [1:0] word offset, [4:2] index (for 8 lines), upper bits tag.
REQ-008 proc_wdata  input  32  store data.
REQ-009 proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0.
REQ-010 proc_stall  output  1  request not yet served; processor holds request stable.
REQ-011 mem_read  output  1  line fill request to slow_memory.
REQ-012 mem_write  output  1  line writeback request to slow_memory.
REQ-013 mem_addr  output  28  line address, equal to word address [29:2].
REQ-014 mem_wdata  output  128  writeback line; word 0 in [31:0], word 3 in [127:96].
REQ-015 mem_rdata  input  128  fill line, same word order.
REQ-016 mem_ready  input  1  one-cycle completion pulse from slow_memory.

Function
REQ-017 Direct-mapped, write-back, write-allocate; per line: valid, dirty, tag, 128-bit data.
REQ-018 FSM states IDLE, WRITEBACK, ALLOCATE; outputs decoded from state (Moore for mem_*).
REQ-019 IDLE, no request: proc_stall=0, no state change; mem_ready ignored.
REQ-020 IDLE, hit (valid and tag equal): proc_stall=0 combinationally in the same cycle; load returns the addressed word; store writes the word and sets dirty at the next edge.
REQ-021 IDLE, miss on clean or invalid line: proc_stall=1, next state ALLOCATE.
REQ-022 IDLE, miss on dirty line: proc_stall=1, next state WRITEBACK.
REQ-023 WRITEBACK: mem_write=1, mem_addr={stored tag, index}, mem_wdata=stored line, held stable; on mem_ready go to ALLOCATE.
REQ-024 ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2], held stable; on mem_ready write mem_rdata into line, set valid=1, dirty=0, tag updated; go to IDLE.
REQ-025 After a fill, the held request hits in IDLE the following cycle; miss latency = memory latency(s) + 1 cycle.
REQ-026 proc_stall=1 in every cycle of WRITEBACK and ALLOCATE.
REQ-027 mem_read and mem_write never both 1; both 0 in IDLE.
REQ-028 proc_read and proc_write both 1 is treated as a write.
REQ-029 proc_rdata = 0 when no hit read is being served.

Reset
REQ-030 rst_n low asynchronously forces IDLE, all valid and dirty bits 0, mem_read=0, mem_write=0; reset mid-WRITEBACK or mid-ALLOCATE abandons the transfer without updating the array.
REQ-031 Data and tag storage need not be reset.

Structure
REQ-032 Shared package holds state encoding, ADDR_W=30, MEM_ADDR_W=28, WORD_W=32, LINE_W=128, derived INDEX_W/TAG_W.
REQ-033 One sub-module dcache_array: register-based tag/valid/dirty/data storage with one read port and one line-or-word write port; FSM and hit logic in dcache_wb.

Verification
REQ-034 Reset, load proc_addr=0x10 -> mem_read=1, mem_addr=0x4 until mem_ready; proc_stall drops one cycle after ready; proc_rdata = word 0 of fill.
REQ-035 Then load proc_addr=0x13 -> hit, proc_stall=0 same cycle, proc_rdata = fill word 3, no mem_* activity.
REQ-036 Store 0xDEADBEEF to 0x11 (hit), then load 0x111 (same index, new tag) -> WRITEBACK with mem_addr=0x4, mem_wdata[63:32]=0xDEADBEEF, then ALLOCATE with mem_addr=0x44.
REQ-037 Assert rst_n low during ALLOCATE -> mem_read=0 immediately; subsequent load of 0x10 misses again.
REQ-038 IDLE with no request, pulse mem_ready -> no state, array, or output change.
